// File: rtl/ram_b_ctrl.sv
// ram_b_ctrl: burst sequencer for the partial-sum (b) layer storage of the
// SCAN polar decoder. Layer-level write/read requests are expanded into
// per-beat enables and beat counts. Reads wait while a write to the same
// layer is pending or in progress. Returned read data is tagged with
// valid/beat/last flags that line up with the registered storage output.
module ram_b_ctrl #(
  parameter int N         = 1024,
  parameter int MAX_LAYER = 8,
  parameter int BEAT_LOG  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [4:0] wr_layer,
  output logic       wr_ready,
  output logic       wr_done,
  input  logic       rd_req,
  input  logic [4:0] rd_layer,
  output logic       rd_ready,
  output logic [4:0] layer_w,
  output logic [3:0] cnta,
  output logic       w_en,
  output logic [4:0] layer_r,
  output logic [3:0] cntb,
  output logic       r_en,
  output logic       rd_valid,
  output logic [3:0] rd_beat,
  output logic       rd_last,
  output logic       layer_err
);

  localparam int LOG_N     = $clog2(N);
  localparam int TOP_LAYER = (MAX_LAYER < LOG_N) ? MAX_LAYER : LOG_N;

  typedef enum logic {W_IDLE, W_BURST} wstate_t;
  typedef enum logic {R_IDLE, R_BURST} rstate_t;

  // A layer is legal when it is non-zero and no deeper than storage and code allow.
  function automatic logic is_legal(input logic [4:0] l);
    return (l != 5'd0) && (int'(l) <= TOP_LAYER);
  endfunction

  // Last beat index of a write burst: a write beat carries 2^(BEAT_LOG+1) values.
  function automatic logic [3:0] wb_last_idx(input logic [4:0] l);
    int n;
    n = 0;
    if (int'(l) > BEAT_LOG + 1) n = (1 << (int'(l) - BEAT_LOG - 1)) - 1;
    return n[3:0];
  endfunction

  // Last beat index of a read burst: a read beat carries 2^BEAT_LOG values.
  function automatic logic [3:0] rb_last_idx(input logic [4:0] l);
    int n;
    n = 0;
    if (int'(l) > BEAT_LOG) n = (1 << (int'(l) - BEAT_LOG)) - 1;
    return n[3:0];
  endfunction

  wstate_t    w_state, w_state_n;
  rstate_t    r_state, r_state_n;
  logic [4:0] layer_w_n, layer_r_n;
  logic [3:0] cnta_n, cntb_n;
  logic [3:0] w_max, w_max_n, r_max, r_max_n;
  logic       w_last, r_last;
  logic       wr_acc, rd_acc, rd_hazard;

  // Write engine registers: state, latched layer, beat counter and burst length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      layer_w <= 5'd0;
      cnta    <= 4'd0;
      w_max   <= 4'd0;
    end else begin
      w_state <= w_state_n;
      layer_w <= layer_w_n;
      cnta    <= cnta_n;
      w_max   <= w_max_n;
    end
  end

  // Write engine next state; the last beat can accept the next burst with no bubble.
  always_comb begin
    w_state_n = w_state;
    layer_w_n = layer_w;
    cnta_n    = cnta;
    w_max_n   = w_max;
    w_en      = 1'b0;
    w_last    = 1'b0;
    if (w_state == W_BURST) begin
      w_en   = 1'b1;
      w_last = (cnta == w_max);
    end
    wr_ready = (w_state == W_IDLE) || w_last;
    wr_done  = w_last;
    wr_acc   = wr_req && wr_ready;
    if (wr_acc && is_legal(wr_layer)) begin
      w_state_n = W_BURST;
      layer_w_n = wr_layer;
      cnta_n    = 4'd0;
      w_max_n   = wb_last_idx(wr_layer);
    end else if (w_state == W_BURST) begin
      if (w_last) w_state_n = W_IDLE;
      else        cnta_n    = cnta + 4'd1;
    end
  end

  // Read engine registers: state, latched layer, beat counter and burst length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      layer_r <= 5'd0;
      cntb    <= 4'd0;
      r_max   <= 4'd0;
    end else begin
      r_state <= r_state_n;
      layer_r <= layer_r_n;
      cntb    <= cntb_n;
      r_max   <= r_max_n;
    end
  end

  // Read engine next state, held off while a write to the same layer is pending.
  always_comb begin
    r_state_n = r_state;
    layer_r_n = layer_r;
    cntb_n    = cntb;
    r_max_n   = r_max;
    r_en      = 1'b0;
    r_last    = 1'b0;
    if (r_state == R_BURST) begin
      r_en   = 1'b1;
      r_last = (cntb == r_max);
    end
    rd_hazard = ((w_state == W_BURST) && (layer_w == rd_layer)) ||
                (wr_acc && (wr_layer == rd_layer));
    rd_ready  = ((r_state == R_IDLE) || r_last) && !rd_hazard;
    rd_acc    = rd_req && rd_ready;
    if (rd_acc && is_legal(rd_layer)) begin
      r_state_n = R_BURST;
      layer_r_n = rd_layer;
      cntb_n    = 4'd0;
      r_max_n   = rb_last_idx(rd_layer);
    end else if (r_state == R_BURST) begin
      if (r_last) r_state_n = R_IDLE;
      else        cntb_n    = cntb + 4'd1;
    end
  end

  // Read-return tags and the shared illegal-layer pulse, one cycle behind the issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      rd_beat   <= 4'd0;
      rd_last   <= 1'b0;
      layer_err <= 1'b0;
    end else begin
      rd_valid  <= r_en;
      rd_beat   <= cntb;
      rd_last   <= r_last;
      layer_err <= (wr_acc && !is_legal(wr_layer)) || (rd_acc && !is_legal(rd_layer));
    end
  end

endmodule

// File: tb/tb_ram_b_ctrl.sv
// tb_ram_b_ctrl: directed bench for ram_b_ctrl. Expected beats are queued
// with their cycle number when a request is driven and compared each cycle.
module tb_ram_b_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, rd_req;
  logic [4:0] wr_layer, rd_layer;
  logic       wr_ready, wr_done, rd_ready;
  logic [4:0] layer_w, layer_r;
  logic [3:0] cnta, cntb, rd_beat;
  logic       w_en, r_en, rd_valid, rd_last, layer_err;

  typedef struct {
    int         cyc;
    logic [4:0] layer;
    logic [3:0] cnt;
    logic       last;
  } beat_t;

  beat_t wq[$];
  beat_t rq[$];
  beat_t vq[$];
  int    eq[$];
  int    cyc = 0;
  int    nAsserts = 0;
  int    nFails = 0;

  ram_b_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_layer(wr_layer), .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_req(rd_req), .rd_layer(rd_layer), .rd_ready(rd_ready),
    .layer_w(layer_w), .cnta(cnta), .w_en(w_en),
    .layer_r(layer_r), .cntb(cntb), .r_en(r_en),
    .rd_valid(rd_valid), .rd_beat(rd_beat), .rd_last(rd_last),
    .layer_err(layer_err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic int wbModel(input int l);
    return (l > 7) ? (1 << (l - 7)) : 1;
  endfunction

  function automatic int rbModel(input int l);
    return (l > 6) ? (1 << (l - 6)) : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic wq_i, input logic [4:0] wl, input logic rq_i, input logic [4:0] rl);
    wr_req   = wq_i;
    wr_layer = wl;
    rd_req   = rq_i;
    rd_layer = rl;
    #1;
  endtask

  task automatic pushWrite(input int acc, input int l);
    int nb;
    nb = wbModel(l);
    for (int i = 0; i < nb; i++)
      wq.push_back('{acc + 1 + i, 5'(l), 4'(i), (i == nb - 1)});
  endtask

  task automatic pushRead(input int acc, input int l);
    int nb;
    nb = rbModel(l);
    for (int i = 0; i < nb; i++) begin
      rq.push_back('{acc + 1 + i, 5'(l), 4'(i), (i == nb - 1)});
      vq.push_back('{acc + 2 + i, 5'(l), 4'(i), (i == nb - 1)});
    end
  endtask

  // Compares this cycle's enables and tags against the scoreboard queues.
  task automatic checkCycle();
    beat_t b;
    if (wq.size() > 0 && wq[0].cyc == cyc) begin
      b = wq.pop_front();
      checkOutput("w_en", 32'(w_en), 32'd1);
      checkOutput("cnta", 32'(cnta), 32'(b.cnt));
      checkOutput("layer_w", 32'(layer_w), 32'(b.layer));
      checkOutput("wr_done", 32'(wr_done), 32'(b.last));
    end else begin
      checkOutput("w_en_idle", 32'(w_en), 32'd0);
      checkOutput("wr_done_idle", 32'(wr_done), 32'd0);
    end
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      b = rq.pop_front();
      checkOutput("r_en", 32'(r_en), 32'd1);
      checkOutput("cntb", 32'(cntb), 32'(b.cnt));
      checkOutput("layer_r", 32'(layer_r), 32'(b.layer));
    end else begin
      checkOutput("r_en_idle", 32'(r_en), 32'd0);
    end
    if (vq.size() > 0 && vq[0].cyc == cyc) begin
      b = vq.pop_front();
      checkOutput("rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("rd_beat", 32'(rd_beat), 32'(b.cnt));
      checkOutput("rd_last", 32'(rd_last), 32'(b.last));
    end else begin
      checkOutput("rd_valid_idle", 32'(rd_valid), 32'd0);
      checkOutput("rd_last_idle", 32'(rd_last), 32'd0);
    end
    if (eq.size() > 0 && eq[0] == cyc) begin
      void'(eq.pop_front());
      checkOutput("layer_err", 32'(layer_err), 32'd1);
    end else begin
      checkOutput("layer_err_idle", 32'(layer_err), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    checkCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkResetState();
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_rd_ready", 32'(rd_ready), 32'd1);
    checkOutput("rst_layer_w", 32'(layer_w), 32'd0);
    checkOutput("rst_cnta", 32'(cnta), 32'd0);
    checkOutput("rst_layer_r", 32'(layer_r), 32'd0);
    checkOutput("rst_cntb", 32'(cntb), 32'd0);
    checkOutput("rst_rd_beat", 32'(rd_beat), 32'd0);
  endtask

  // Directed sequence: reset, single bursts, hazards, back-to-back, illegal, reset abort.
  initial begin
    rst = 1'b1;
    wr_req = 1'b0; wr_layer = 5'd0; rd_req = 1'b0; rd_layer = 5'd0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkCycle();
    checkResetState();

    // Write layer 8: two beats, done on the second.
    applyStimulus(1'b1, 5'd8, 1'b0, 5'd0);
    checkOutput("wr_ready_w8", 32'(wr_ready), 32'd1);
    pushWrite(cyc, 8);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    idle(4);

    // Read layer 8: four beats, tags one cycle later.
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd8);
    checkOutput("rd_ready_r8", 32'(rd_ready), 32'd1);
    pushRead(cyc, 8);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    idle(6);

    // Read-after-write on layer 8 waits for the write burst to finish.
    applyStimulus(1'b1, 5'd8, 1'b1, 5'd8);
    checkOutput("raw_rd_ready_c0", 32'(rd_ready), 32'd0);
    checkOutput("raw_wr_ready_c0", 32'(wr_ready), 32'd1);
    pushWrite(cyc, 8);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd8);
    checkOutput("raw_rd_ready_c1", 32'(rd_ready), 32'd0);
    tick();
    checkOutput("raw_rd_ready_c2", 32'(rd_ready), 32'd0);
    tick();
    checkOutput("raw_rd_ready_c3", 32'(rd_ready), 32'd1);
    pushRead(cyc, 8);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    idle(6);

    // Write layer 8 with a concurrent read of layer 5.
    applyStimulus(1'b1, 5'd8, 1'b1, 5'd5);
    checkOutput("conc_rd_ready", 32'(rd_ready), 32'd1);
    pushWrite(cyc, 8);
    pushRead(cyc, 5);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    idle(4);

    // Write layer 2 with a concurrent two-beat read of layer 7.
    applyStimulus(1'b1, 5'd2, 1'b1, 5'd7);
    checkOutput("conc7_rd_ready", 32'(rd_ready), 32'd1);
    pushWrite(cyc, 2);
    pushRead(cyc, 7);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    idle(4);

    // Back-to-back single-beat writes on layer 3.
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
    pushWrite(cyc, 3);
    tick();
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
    checkOutput("b2b_wr_ready", 32'(wr_ready), 32'd1);
    pushWrite(cyc, 3);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    idle(3);

    // Illegal layers on both sides: one error pulse, no enables.
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd0);
    checkOutput("ill_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("ill_rd_ready", 32'(rd_ready), 32'd1);
    eq.push_back(cyc + 1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    checkOutput("ill_wr_ready_after", 32'(wr_ready), 32'd1);
    checkOutput("ill_rd_ready_after", 32'(rd_ready), 32'd1);
    checkOutput("ill_layer_w_hold", 32'(layer_w), 32'd3);
    idle(3);

    // Reset in the middle of a four-beat read abandons the burst at once.
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd8);
    pushRead(cyc, 8);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    #3 rst = 1'b1;
    #1;
    checkOutput("abort_r_en", 32'(r_en), 32'd0);
    checkOutput("abort_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("abort_cntb", 32'(cntb), 32'd0);
    wq.delete();
    rq.delete();
    vq.delete();
    eq.delete();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #3 rst = 1'b0;
    #1;
    checkCycle();
    checkResetState();
    idle(3);

    checkOutput("queues_drained", 32'(wq.size() + rq.size() + vq.size() + eq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/ram_b_ctrl.md
# ram_b_ctrl

Burst sequencer for the partial-sum (b) layer storage of the SCAN polar decoder. It accepts layer-level write and read requests from the decoder datapath over independent ready/valid handshakes. It expands each request into per-beat `w_en`/`cnta` and `r_en`/`cntb` strobes for the storage, and blocks read-after-write hazards on the same layer. It also tags returned read data with valid, beat and last flags.

## Interface
- `N`, 1024: code length; `log2(N)` bounds layer numbering.
- `MAX_LAYER`, 8: highest layer held in storage; layers `1..MAX_LAYER` are legal.
- `BEAT_LOG`, 6: log2 of the number of values per read beat (64). A write beat carries twice that.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `wr_req` in 1: write request.
- `wr_layer` in 5: layer to write.
- `wr_ready` out 1: write request accepted when `wr_req & wr_ready`.
- `wr_done` out 1: one-cycle pulse coincident with the last write beat.
- `rd_req` in 1: read request.
- `rd_layer` in 5: layer to read.
- `rd_ready` out 1: read request accepted when `rd_req & rd_ready`.
- `layer_w` out 5: storage write layer.
- `cnta` out 4: storage write beat count.
- `w_en` out 1: storage write enable.
- `layer_r` out 5: storage read layer.
- `cntb` out 4: storage read beat count.
- `r_en` out 1: storage read enable.
- `rd_valid` out 1: storage output holds valid read data this cycle.
- `rd_beat` out 4: beat index of the data on `rd_valid`.
- `rd_last` out 1: final beat of the read burst.
- `layer_err` out 1: one-cycle pulse, illegal layer requested.

## Operation
- Write beats per layer: `WB(L) = 2^(L-BEAT_LOG-1)` if `L > BEAT_LOG+1`, else 1. Default layer 8 = 2, layers 1..7 = 1.
- Read beats per layer: `RB(L) = 2^(L-BEAT_LOG)` if `L > BEAT_LOG`, else 1. Default layer 8 = 4, layer 7 = 2, layers 1..6 = 1.
- Write engine FSM, states IDLE and WBURST.
  - IDLE→WBURST on an accepted legal request. `layer_w` latches `wr_layer` and `cnta` = 0.
  - In WBURST, `w_en` = 1. `cnta` increments each cycle up to `WB-1`.
  - On the last beat, `wr_done` = 1. The engine returns to IDLE, or re-enters WBURST at `cnta` = 0 if a new request is accepted in that same cycle.
- Read engine FSM, states IDLE and RBURST. It mirrors the write engine, using `r_en`, `cntb`, `layer_r` and `RB`.
- `wr_ready` = IDLE | (WBURST & last beat). `rd_ready` is defined the same way for the read engine, then gated by the hazard rules below. This allows back-to-back bursts with no bubble.
- Hazard rules: `rd_ready` is forced 0 in either of these cases:
  - the write engine is in WBURST with `layer_w == rd_layer`, including its last beat;
  - a write to `rd_layer` is being accepted this cycle.
  - Writes have priority. Reads to other layers proceed concurrently with writes.
- Illegal layer (0 or > `MAX_LAYER`):
  - The request is accepted normally.
  - No enables are issued, and the engine stays in or returns to IDLE.
  - `layer_err` pulses in the following cycle. If both requests are illegal, one pulse covers both.
- Read return:
  - `rd_valid`, `rd_beat` and `rd_last` are `r_en`, `cntb` and (last beat) each delayed one cycle. This matches the registered storage output.
- Outside bursts, `w_en` and `r_en` are 0. `layer_w`, `layer_r`, `cnta` and `cntb` hold their last values.

## Timing
- Reset (asynchronous, immediate):
  - FSMs → IDLE.
  - All outputs 0 except `wr_ready` and `rd_ready`, which are 1 on the first cycle after `rst` deasserts.
  - Any in-flight burst is abandoned with no further enables and no `wr_done` or `rd_valid`.
- Request accepted at edge k → first `w_en`/`r_en` high in cycle k+1.
- Read data for the beat issued in cycle j → `rd_valid` high in cycle j+1.
- Burst of B beats: enables high for exactly B consecutive cycles.
- `rd_ready` is combinational from `rd_layer`, `wr_req` and `wr_layer`. `wr_ready` is purely registered-state.
- Counters never exceed `B-1`. No wrap-around within a burst.

## Test plan
- Reset: assert `rst` mid-cycle during a 4-beat read → `r_en` and `rd_valid` drop immediately. After release, `wr_ready` = `rd_ready` = 1 and all other outputs are 0.
- Write layer 8 accepted at edge 0 → `w_en` high in cycles 1–2 with `cnta` 0,1, `layer_w` = 8, and `wr_done` only in cycle 2.
- Read layer 8 accepted at edge 0 → `r_en` in cycles 1–4 with `cntb` 0..3. `rd_valid` in cycles 2–5, `rd_beat` 0..3, and `rd_last` only in cycle 5.
- RAW hazard: write layer 8 accepted at edge 0, with `rd_req` layer 8 held → `rd_ready` = 0 through cycle 2, read accepted at edge 3, `r_en` starts in cycle 4. The same stimulus with a layer 5 read → read accepted at edge 0.
- Back-to-back: two layer-3 writes, the second requested while the first issues its beat → `w_en` high in cycles 1 and 2 with no gap, and two `wr_done` pulses.
- Illegal layer: `wr_layer` = 9 and `rd_layer` = 0 accepted at edge 0 → `layer_err` pulses in cycle 1 with no `w_en`/`r_en`, and both ready signals return to 1.
